pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: PC_W, 8, program-counter width in bits.
REQ-002 Parameter: RESET_PC, 8'h00, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 stall  input  1  hold current PC this cycle.
REQ-006 jump  input  1  redirect to jump_target.
REQ-007 jump_target  input  PC_W  absolute jump address.
REQ-008 branch_taken  input  1  redirect to PC-relative target.
REQ-009 branch_offset  input  PC_W  two's-complement offset, relative to pc_plus1.
REQ-010 halt_req  input  1  stop fetching permanently until reset.
REQ-011 pc  output  PC_W  current fetch address, registered.
REQ-012 pc_plus1  output  PC_W  pc+1 mod 2^PC_W, combinational from pc.
REQ-013 fetch_valid  output  1  pc is a valid fetch address this cycle, registered.
REQ-014 halted  output  1  sequencer in HALT, registered.

Function
REQ-015 The block SHALL implement a three-state FSM: BOOT, RUN, HALT.
REQ-016 BOOT: pc=RESET_PC, fetch_valid=0; on the first clock edge with reset=1, go to RUN, pc stays RESET_PC.
REQ-017 RUN: fetch_valid=1; next pc chosen by priority halt_req > stall > jump > branch_taken > increment.
REQ-018 halt_req in RUN: go to HALT next edge, pc holds, fetch_valid=0 and halted=1 from that edge.
REQ-019 stall in RUN: pc holds, fetch_valid stays 1; any jump/branch_taken in the same cycle is ignored and the requester SHALL re-assert it.
REQ-020 jump: next pc = jump_target.
REQ-021 branch_taken: next pc = (pc_plus1 + branch_offset) mod 2^PC_W, sign-extended offset, carry discarded.
REQ-022 Increment: next pc = pc_plus1; 8'hFF wraps to 8'h00 with no flag and no state change.
REQ-023 HALT: absorbing; all inputs ignored; pc holds; exit only via reset.
REQ-024 Redirect latency: pc shows the new address exactly one clock after the request cycle.
REQ-025 Inputs are sampled only in RUN; in BOOT they SHALL have no effect.

Reset
REQ-026 reset=0 SHALL asynchronously set state=BOOT, pc=RESET_PC, fetch_valid=0, halted=0, regardless of clk.
REQ-027 Reset asserted mid-redirect or mid-stall SHALL discard the pending request; no stale value appears after release.
REQ-028 Reset release SHALL be followed by exactly one BOOT cycle before RUN.

Structure
REQ-029 State encoding (BOOT=2'b00, RUN=2'b01, HALT=2'b10), PC_W default and RESET_PC default SHALL live in the shared CPU package.
REQ-030 The next-address arithmetic (increment and branch add) SHALL be one sub-module, pc_next_adder, purely combinational; pc_sequencer holds all registers and the FSM.
REQ-031 No latches; all outputs except pc_plus1 come directly from flops.

Verification
REQ-032 Reset pulse then 3 idle cycles -> pc: 00 (BOOT, fetch_valid=0), 00, 01, 02 with fetch_valid=1 from cycle 2.
REQ-033 pc=FE, 3 increments -> FF, 00, 01; no glitch on fetch_valid.
REQ-034 pc=10, branch_taken with offset 8'hF0 (-16) -> next pc=01; offset 8'h05 from pc=FC -> next pc=02 (wrap).
REQ-035 pc=20, stall+jump(target 80) for 2 cycles, then jump alone -> pc 20, 20, 80.
REQ-036 pc=30, halt_req+jump(target 90) -> pc stays 30, halted=1, fetch_valid=0; further jumps ignored for 10 cycles.
REQ-037 reset=0 asserted between clock edges during a branch cycle -> pc=RESET_PC immediately, one BOOT cycle after release, no branch target ever appears.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU sequencer definitions: FSM state encoding and default PC geometry.
package pc_sequencer_pkg;

  localparam int unsigned PC_W_DEF = 8;
  localparam logic [PC_W_DEF-1:0] RESET_PC_DEF = 8'h00;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } seq_state_e;

endpackage

// File: rtl/pc_next_adder.sv
// Next-address arithmetic for the sequencer: pc+1 and the PC-relative branch target.
// Purely combinational; all sums wrap modulo 2^PC_W.
module pc_next_adder #(
  parameter int unsigned PC_W = 8
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] offset_i,
  output logic [PC_W-1:0] pc_plus1_o,
  output logic [PC_W-1:0] branch_tgt_o
);

  assign pc_plus1_o = pc_i + PC_W'(1);
  // Offset already spans PC_W bits, so a same-width add is the sign-extended add with carry dropped.
  assign branch_tgt_o = pc_plus1_o + offset_i;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT -> RUN -> HALT FSM choosing the next fetch address.
// Redirects appear on pc one clock after the request; stall holds pc without dropping fetch_valid.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_offset,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic            fetch_valid,
  output logic            halted
);

  seq_state_e      state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            fetch_valid_q;
  logic            halted_q;
  logic [PC_W-1:0] branch_tgt;

  pc_next_adder #(.PC_W(PC_W)) u_adder (
    .pc_i         (pc_q),
    .offset_i     (branch_offset),
    .pc_plus1_o   (pc_plus1),
    .branch_tgt_o (branch_tgt)
  );

  // halt_req is resolved in the FSM below; this only ranks the RUN-state redirects.
  always_comb begin
    pc_d = pc_plus1;
    if (stall) begin
      pc_d = pc_q;
    end else if (jump) begin
      pc_d = jump_target;
    end else if (branch_taken) begin
      pc_d = branch_tgt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q       <= ST_RUN;
          fetch_valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (halt_req) begin
            state_q       <= ST_HALT;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else begin
            pc_q <= pc_d;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q       <= ST_BOOT;
          pc_q          <= RESET_PC;
          fetch_valid_q <= 1'b0;
          halted_q      <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign halted      = halted_q;

endmodule
